bus_arb: RTL

Two-master arbiter that shares the single `busctl` port between the CPU domain (master 0) and the debug unit (master 1). It sits between the requesters and `busctl` and owns `bus_addr`, `bus_we` and the bus write data. Ownership uses a registered request/grant handshake with a burst limit so neither master can starve the other. Read data from `busctl` is returned to both masters; only the granted master may consume it.

---
 rtl/bus_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bus_arb.sv
// Two-master bus arbiter in front of busctl: registered request/grant with a burst limit.
// Define BUS_ARB_RR_EN for round-robin tie-break in IDLE; otherwise master 1 wins ties.
module bus_arb #(
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   output logic              m0_gnt,
   output logic              m1_gnt,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m0_we,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

   state_t     state_r;
   state_t     state_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_s;
   logic       last_r;
   logic       last_s;
   logic       m0_gnt_r;
   logic       m1_gnt_r;
   logic       expired_s;
   logic       tie_m1_s;

   assign expired_s = (cnt_r == CNT_MAX);

`ifdef BUS_ARB_RR_EN
   assign tie_m1_s = ~last_r;
`else
   assign tie_m1_s = 1'b1;
`endif

   // State, burst counter, priority pointer and grant registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         cnt_r    <= 8'd0;
         last_r   <= 1'b1;
         m0_gnt_r <= 1'b0;
         m1_gnt_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         last_r   <= last_s;
         m0_gnt_r <= (state_s == OWN0);
         m1_gnt_r <= (state_s == OWN1);
      end
   end

   // Next owner: release, expiry handoff and IDLE tie-break
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_s = tie_m1_s ? OWN1 : OWN0;
            end else if (m0_req) begin
               state_s = OWN0;
            end else if (m1_req) begin
               state_s = OWN1;
            end else begin
               state_s = IDLE;
            end
         end
         OWN0: begin
            if (!m0_req) begin
               state_s = m1_req ? OWN1 : IDLE;
            end else if (expired_s && m1_req) begin
               state_s = OWN1;
            end else begin
               state_s = OWN0;
            end
         end
         OWN1: begin
            if (!m1_req) begin
               state_s = m0_req ? OWN0 : IDLE;
            end else if (expired_s && m0_req) begin
               state_s = OWN0;
            end else begin
               state_s = OWN1;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Counter restarts on any ownership change and saturates while the owner keeps the bus
   always_comb begin
      cnt_s  = cnt_r;
      last_s = last_r;
      if (state_s != state_r) begin
         cnt_s = 8'd0;
         if (state_s == OWN0) begin
            last_s = 1'b0;
         end else if (state_s == OWN1) begin
            last_s = 1'b1;
         end else begin
            last_s = last_r;
         end
      end else if ((state_r != IDLE) && !expired_s) begin
         cnt_s = cnt_r + 8'd1;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Bus mux follows the registered owner so async reset idles it immediately
   always_comb begin
      bus_addr  = {ADDR_W{1'b0}};
      bus_we    = 1'b0;
      bus_wdata = {DATA_W{1'b0}};
      case (state_r)
         OWN0: begin
            bus_addr  = m0_addr;
            bus_we    = m0_we;
            bus_wdata = m0_wdata;
         end
         OWN1: begin
            bus_addr  = m1_addr;
            bus_we    = m1_we;
            bus_wdata = m1_wdata;
         end
         default: begin
            bus_addr  = {ADDR_W{1'b0}};
            bus_we    = 1'b0;
            bus_wdata = {DATA_W{1'b0}};
         end
      endcase
   end

   assign m0_gnt   = m0_gnt_r;
   assign m1_gnt   = m1_gnt_r;
   assign bus_busy = m0_gnt_r | m1_gnt_r;
   assign m0_rdata = bus_rdata;
   assign m1_rdata = bus_rdata;

endmodule
